// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm sounder slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING     = 2'd1,
    SNOOZE   = 2'd2,
    WAIT_CLR = 2'd3
  } alarm_state_e;

  localparam int unsigned TONE_DIV_DEF   = 12500;
  localparam int unsigned BEEP_DIV_DEF   = 12500000;
  localparam int unsigned SEC_DIV_DEF    = 50000000;
  localparam int unsigned RING_SEC_DEF   = 60;
  localparam int unsigned SNOOZE_SEC_DEF = 300;
  localparam int unsigned DEB_CNT_DEF    = 1000000;

  // Counter width for a divisor; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? int'($clog2(div)) : 1;
  endfunction

endpackage

// File: rtl/alarm_sounder_key.sv
// key_debounce: 2-FF synchroniser plus debouncer emitting a one-cycle pulse
// once the key has been stable high for DEB_CNT cycles; re-arms only after
// DEB_CNT stable-low cycles.
module key_debounce
  import alarm_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEB_CNT_DEF
) (
  input  logic clk_50,
  input  logic ncr,
  input  logic key_raw,
  output logic key_pulse
);

  localparam int unsigned    CW       = cnt_width(DEB_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronised key differs from the accepted level.
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    cnt_d     = '0;
    key_pulse = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        key_pulse = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_50 or negedge ncr) begin
    if (!ncr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_sounder.sv
// alarm_sounder: turns the alarm-match level into a beeping buzzer tone with
// stop, snooze and auto-timeout. Optional feature macro: ALARM_SNOOZE_EN
// (snooze key and SNOOZE state; when undefined snoozing is tied low).
module alarm_sounder
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_DIV   = TONE_DIV_DEF,
  parameter int unsigned BEEP_DIV   = BEEP_DIV_DEF,
  parameter int unsigned SEC_DIV    = SEC_DIV_DEF,
  parameter int unsigned RING_SEC   = RING_SEC_DEF,
  parameter int unsigned SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int unsigned DEB_CNT    = DEB_CNT_DEF
) (
  input  logic clk_50,
  input  logic ncr,
  input  logic alarm_match,
  input  logic alarm_on,
  input  logic stop_key,
  input  logic snooze_key,
  output logic buzzer,
  output logic ringing,
  output logic snoozing
);

  localparam int unsigned   TW = cnt_width(TONE_DIV);
  localparam int unsigned   BW = cnt_width(BEEP_DIV);
  localparam int unsigned   SW = cnt_width(SEC_DIV);
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEP_DIV - 1);
  localparam logic [SW-1:0] TICK_LAST   = SW'(SEC_DIV - 1);
  localparam logic [8:0]    RING_LAST   = 9'(RING_SEC - 1);
  localparam logic [8:0]    SNOOZE_LAST = 9'(SNOOZE_SEC - 1);

  alarm_state_e  state_q, state_d;
  logic          match_q, match_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_q, tone_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;
  logic [SW-1:0] tick_cnt_q, tick_cnt_d;
  logic [8:0]    sec_cnt_q, sec_cnt_d;
  logic          buzzer_q, buzzer_d;
  logic          ringing_q, ringing_d;

  logic match_rise, tick, enter_ring, enter_timed;
  logic stop_pulse, snooze_pulse;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_stop_deb (
    .clk_50    (clk_50),
    .ncr       (ncr),
    .key_raw   (stop_key),
    .key_pulse (stop_pulse)
  );

`ifdef ALARM_SNOOZE_EN
  key_debounce #(.DEB_CNT(DEB_CNT)) u_snooze_deb (
    .clk_50    (clk_50),
    .ncr       (ncr),
    .key_raw   (snooze_key),
    .key_pulse (snooze_pulse)
  );
`else
  logic snooze_key_unused;
  assign snooze_key_unused = snooze_key;
  assign snooze_pulse      = 1'b0;
`endif

  assign match_rise = alarm_match & ~match_q;
  assign tick       = (tick_cnt_q == TICK_LAST);

  // Next-state logic; alarm_on low overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (match_rise) state_d = RING;
      RING: begin
        if (stop_pulse)                          state_d = WAIT_CLR;
        else if (snooze_pulse)                   state_d = SNOOZE;
        else if (tick && sec_cnt_q == RING_LAST) state_d = WAIT_CLR;
      end
      SNOOZE: begin
        if (stop_pulse)                            state_d = WAIT_CLR;
        else if (tick && sec_cnt_q == SNOOZE_LAST) state_d = RING;
      end
      WAIT_CLR: if (!alarm_match) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (!alarm_on) state_d = IDLE;
  end

  // Tone, cadence and seconds counters; output decodes use next-cycle values
  // so the registered outputs line up with the state register.
  always_comb begin
    enter_ring  = (state_d == RING) && (state_q != RING);
    enter_timed = enter_ring || ((state_d == SNOOZE) && (state_q != SNOOZE));
    match_d     = alarm_match;

    tone_cnt_d = tone_cnt_q + 1'b1;
    tone_d     = tone_q;
    if (enter_ring) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end

    beep_cnt_d = beep_cnt_q + 1'b1;
    beep_d     = beep_q;
    if (enter_ring) begin
      beep_cnt_d = '0;
      beep_d     = 1'b1;
    end else if (beep_cnt_q == BEEP_LAST) begin
      beep_cnt_d = '0;
      beep_d     = ~beep_q;
    end

    tick_cnt_d = (enter_timed || tick) ? '0 : tick_cnt_q + 1'b1;

    sec_cnt_d = sec_cnt_q;
    if (enter_timed) begin
      sec_cnt_d = '0;
    end else if (tick && (state_q == RING || state_q == SNOOZE) && sec_cnt_q != '1) begin
      sec_cnt_d = sec_cnt_q + 1'b1;
    end

    buzzer_d  = (state_d == RING) & beep_d & tone_d;
    ringing_d = (state_d == RING);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_50 or negedge ncr) begin
    if (!ncr) begin
      state_q    <= IDLE;
      match_q    <= 1'b1;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
      tick_cnt_q <= '0;
      sec_cnt_q  <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
      tick_cnt_q <= tick_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= ringing_d;
    end
  end

  assign buzzer  = buzzer_q;
  assign ringing = ringing_q;

`ifdef ALARM_SNOOZE_EN
  logic snoozing_q, snoozing_d;

  // Snooze status decode.
  always_comb begin
    snoozing_d = (state_d == SNOOZE);
  end

  // Snooze status register.
  always_ff @(posedge clk_50 or negedge ncr) begin
    if (!ncr) snoozing_q <= 1'b0;
    else      snoozing_q <= snoozing_d;
  end

  assign snoozing = snoozing_q;
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sounder.sv
// Directed bench for alarm_sounder with small divisors.
module tb_alarm_sounder;

  logic clk_50 = 1'b0;
  logic ncr = 1'b0;
  logic alarm_match = 1'b0;
  logic alarm_on = 1'b1;
  logic stop_key = 1'b0;
  logic snooze_key = 1'b0;
  logic buzzer, ringing, snoozing;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic am;
    logic on;
    logic stop;
    logic snz;
    logic e_buz;
    logic e_ring;
    logic e_snz;
  } vec_t;

  vec_t tbl[$];

  alarm_sounder #(
    .TONE_DIV   (2),
    .BEEP_DIV   (8),
    .SEC_DIV    (16),
    .RING_SEC   (4),
    .SNOOZE_SEC (3),
    .DEB_CNT    (3)
  ) dut (
    .clk_50      (clk_50),
    .ncr         (ncr),
    .alarm_match (alarm_match),
    .alarm_on    (alarm_on),
    .stop_key    (stop_key),
    .snooze_key  (snooze_key),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void add(input logic am, on, stop, snz, e_buz, e_ring, e_snz);
    vec_t v;
    v.am = am; v.on = on; v.stop = stop; v.snz = snz;
    v.e_buz = e_buz; v.e_ring = e_ring; v.e_snz = e_snz;
    tbl.push_back(v);
  endfunction

  // Re-arm from WAIT_CLR/IDLE: drop match for a cycle, then raise it.
  task automatic rearm();
    alarm_match = 1'b0;
    step();
    alarm_match = 1'b1;
    step();
  endtask

  initial begin
    logic [15:0] buz_pat;
    buz_pat = 16'b0000_0000_1100_1100;

    // Idle cycles, the match rise, then one full cadence period of buzzer.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) add(1'b1, 1'b1, 1'b0, 1'b0, buz_pat[k], 1'b1, 1'b0);

    // Reset state
    #12;
    check("rst_buzzer", buzzer, 1'b0);
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    @(posedge clk_50);
    #1;
    ncr = 1'b1;

    // 1. Ring on match rise, tone/cadence pattern, timeout after 64 cycles
    for (int i = 0; i < tbl.size(); i++) begin
      alarm_match = tbl[i].am;
      alarm_on    = tbl[i].on;
      stop_key    = tbl[i].stop;
      snooze_key  = tbl[i].snz;
      step();
      check($sformatf("vec%0d_buzzer", i), buzzer, tbl[i].e_buz);
      check($sformatf("vec%0d_ringing", i), ringing, tbl[i].e_ring);
      check($sformatf("vec%0d_snoozing", i), snoozing, tbl[i].e_snz);
    end
    steps(3);
    check("t1_buz_k18", buzzer, 1'b1);
    steps(45);
    check("t1_ring_k63", ringing, 1'b1);
    step();
    check("t1_timeout_ring", ringing, 1'b0);
    check("t1_timeout_buz", buzzer, 1'b0);
    steps(16);
    check("t1_waitclr_hold", ringing, 1'b0);
    rearm();
    check("t1_rearm_ring", ringing, 1'b1);

    // 2. Stop key ends ringing within 5 cycles; no re-ring while match held
    stop_key = 1'b1;
    steps(5);
    stop_key = 1'b0;
    check("t2_stop_ring", ringing, 1'b0);
    check("t2_stop_buz", buzzer, 1'b0);
    alarm_match = 1'b1;
    steps(20);
    check("t2_no_rering", ringing, 1'b0);

    // 3. Snooze during RING
    rearm();
    check("t3_ring", ringing, 1'b1);
    snooze_key = 1'b1;
    steps(5);
    snooze_key = 1'b0;
`ifdef ALARM_SNOOZE_EN
    check("t3_snz_on", snoozing, 1'b1);
    check("t3_snz_ring", ringing, 1'b0);
    check("t3_snz_buz", buzzer, 1'b0);
    for (int i = 1; i < 48; i++) begin
      step();
      check($sformatf("t3_snz_buz_c%0d", i), buzzer, 1'b0);
    end
    check("t3_snz_held", snoozing, 1'b1);
    step();
    check("t3_rering", ringing, 1'b1);
    check("t3_rering_snz", snoozing, 1'b0);
    steps(63);
    check("t3_restart_k63", ringing, 1'b1);
    step();
    check("t3_restart_timeout", ringing, 1'b0);
`else
    check("t3_nosnz_ring", ringing, 1'b1);
    check("t3_nosnz_snz", snoozing, 1'b0);
    stop_key = 1'b1;
    steps(5);
    stop_key = 1'b0;
    check("t3_nosnz_stop", ringing, 1'b0);
    steps(10);
`endif

    // 4. Stop and snooze in the same cycle: stop wins
    rearm();
    check("t4_ring", ringing, 1'b1);
    stop_key   = 1'b1;
    snooze_key = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("t4_snz_c%0d", i), snoozing, 1'b0);
    end
    check("t4_stop_ring", ringing, 1'b0);
    stop_key   = 1'b0;
    snooze_key = 1'b0;
    steps(12);
    check("t4_after_snz", snoozing, 1'b0);
    check("t4_after_ring", ringing, 1'b0);

    // 5a. alarm_on drop mid-RING takes effect on the next edge
    rearm();
    steps(2);
    check("t5_buz_before", buzzer, 1'b1);
    alarm_on = 1'b0;
    step();
    check("t5_off_buz", buzzer, 1'b0);
    check("t5_off_ring", ringing, 1'b0);
    alarm_on = 1'b1;
    steps(10);
    check("t5_on_no_ring", ringing, 1'b0);

    // 5b. Asynchronous reset mid-SNOOZE (mid-RING without snooze)
    rearm();
`ifdef ALARM_SNOOZE_EN
    snooze_key = 1'b1;
    steps(5);
    snooze_key = 1'b0;
    check("t5_pre_snz", snoozing, 1'b1);
`else
    steps(5);
    check("t5_pre_ring", ringing, 1'b1);
`endif
    steps(5);
    #3;
    ncr = 1'b0;
    #1;
    check("t5_arst_buz", buzzer, 1'b0);
    check("t5_arst_ring", ringing, 1'b0);
    check("t5_arst_snz", snoozing, 1'b0);
    steps(2);
    ncr = 1'b1;
    steps(20);
    check("t5_rel_ring", ringing, 1'b0);
    check("t5_rel_snz", snoozing, 1'b0);

    // 6. Key bounce 1-0-1-0 with 2-cycle widths gives no pulse
    rearm();
    check("t6_ring", ringing, 1'b1);
    for (int i = 0; i < 8; i++) begin
      stop_key = ((i / 2) % 2 == 0);
      step();
      check($sformatf("t6_bounce_c%0d", i), ringing, 1'b1);
    end
    stop_key = 1'b0;
    steps(10);
    check("t6_settled", ringing, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
